// File: rtl/a2d_seq.sv
// Conversion sequencer in front of the 16-bit SPI master: one request becomes a
// channel-select transaction plus a result transaction. Optional A2D_AVG4_EN averages 4 conversions.
module a2d_seq #(
  parameter int GAP_CYC = 2,
  parameter int TO_CYC  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        strt_cnv,
  input  logic [2:0]  chnl,
  output logic        busy,
  output logic        cnv_cmplt,
  output logic [11:0] res,
  output logic        err,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data
);

  localparam int TW = $clog2(TO_CYC);
  localparam int GW = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC);
  localparam logic [TW-1:0] TO_MAX   = TW'(TO_CYC - 1);
  localparam logic [TW-1:0] TO_PRE   = TW'(TO_CYC - 2);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    TX1  = 3'd1,
    WT1  = 3'd2,
    GAP  = 3'd3,
    TX2  = 3'd4,
    WT2  = 3'd5
  } state_t;

  state_t        state, nxt;
  logic [2:0]    chnl_q;
  logic [TW-1:0] to_cnt;
  logic [GW-1:0] gap_cnt;
  logic          accept, to_fire, finish, to_hit, waiting;
  logic          last_pass, gap_to_tx1;
  logic [11:0]   res_nxt;

  assign busy    = (state != IDLE);
  assign wrt     = (state == TX1) || (state == TX2);
  assign cmd     = {2'b00, chnl_q, 11'h000};
  assign waiting = (state == WT1) || (state == WT2);
  // The increment taken this cycle would land on TO_CYC-1: that is the timeout edge.
  assign to_hit  = (to_cnt == TO_PRE);

  logic unused_hi;
  assign unused_hi = ^rd_data[15:12];

`ifdef A2D_AVG4_EN
  logic [1:0]  pass;
  logic [13:0] acc;
  logic [13:0] sum;
  logic        pass_adv;
  logic        gap_from_wt2;

  assign sum       = acc + {2'b00, rd_data[11:0]};
  assign res_nxt   = sum[13:2];
  assign last_pass = (pass == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass       <= 2'd0;
      acc        <= 14'd0;
      gap_to_tx1 <= 1'b0;
    end else begin
      if (accept) begin
        pass <= 2'd0;
        acc  <= 14'd0;
      end else if (pass_adv) begin
        pass <= pass + 2'd1;
        acc  <= sum;
      end
      if (nxt == GAP && state != GAP) gap_to_tx1 <= gap_from_wt2;
    end
  end
`else
  assign res_nxt    = rd_data[11:0];
  assign last_pass  = 1'b1;
  assign gap_to_tx1 = 1'b0;
`endif

  always_comb begin
    nxt     = state;
    accept  = 1'b0;
    to_fire = 1'b0;
    finish  = 1'b0;
`ifdef A2D_AVG4_EN
    pass_adv     = 1'b0;
    gap_from_wt2 = 1'b0;
`endif
    case (state)
      IDLE: if (strt_cnv) begin
        accept = 1'b1;
        nxt    = TX1;
      end
      TX1: nxt = WT1;
      WT1: begin
        if (done) nxt = GAP;
        else if (to_hit) begin
          to_fire = 1'b1;
          nxt     = IDLE;
        end
      end
      GAP: if (gap_cnt == GAP_LAST) nxt = gap_to_tx1 ? TX1 : TX2;
      TX2: nxt = WT2;
      WT2: begin
        if (done) begin
          if (last_pass) begin
            finish = 1'b1;
            nxt    = IDLE;
          end else begin
`ifdef A2D_AVG4_EN
            pass_adv     = 1'b1;
            gap_from_wt2 = 1'b1;
`endif
            nxt = GAP;
          end
        end else if (to_hit) begin
          to_fire = 1'b1;
          nxt     = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      chnl_q    <= 3'd0;
      to_cnt    <= '0;
      gap_cnt   <= '0;
      err       <= 1'b0;
      cnv_cmplt <= 1'b0;
      res       <= 12'h000;
    end else begin
      state     <= nxt;
      cnv_cmplt <= finish;
      if (accept) begin
        chnl_q <= chnl;
        err    <= 1'b0;
      end else if (to_fire) begin
        err <= 1'b1;
      end
      if (finish) res <= res_nxt;
      if (wrt) to_cnt <= '0;
      else if (waiting && to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
      // Gap counter only runs inside GAP; any other state leaves it cleared for the next entry.
      if (state != GAP) gap_cnt <= '0;
      else if (gap_cnt != GAP_LAST) gap_cnt <= gap_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_a2d_seq.sv
// Directed bench for a2d_seq with a behavioural SPI master (done 40 cycles after wrt)
// and scoreboard queues for expected command words and results.
module tb_a2d_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        strt_cnv = 1'b0;
  logic [2:0]  chnl = 3'd0;
  logic        busy, cnv_cmplt, err, wrt;
  logic [11:0] res;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data = 16'h0000;
  logic        resp_done = 1'b0;
  logic        stray_done = 1'b0;
  bit          resp_en = 1'b0;

  int ncmp = 0, nbad = 0;
  int cyc = 0, wrt_cnt = 0, cmplt_cnt = 0, last_wrt = 0, prev_wrt = 0;
  int n0, c0;

  logic [15:0] exp_cmd[$];
  logic [11:0] exp_res[$];
  logic [15:0] rd_q[$];

  assign done = resp_done | stray_done;

  a2d_seq #(.GAP_CYC(2), .TO_CYC(64)) dut (
    .clk(clk), .rst(rst), .strt_cnv(strt_cnv), .chnl(chnl), .busy(busy),
    .cnv_cmplt(cnv_cmplt), .res(res), .err(err), .wrt(wrt), .cmd(cmd),
    .done(done), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_cmplt(input string tag, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cnv_cmplt && n < budget);
    chk({tag, "_cmplt_seen"}, 16'(cnv_cmplt), 16'h1);
  endtask

  task automatic start(input logic [2:0] ch);
    chnl = ch;
    strt_cnv = 1'b1;
    @(negedge clk);
    strt_cnv = 1'b0;
  endtask

  // Monitor: every wrt pops an expected cmd, every cnv_cmplt pops an expected result.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (wrt) begin
      wrt_cnt++;
      prev_wrt = last_wrt;
      last_wrt = cyc;
      if (exp_cmd.size() == 0) chk("wrt_unexpected", 16'h1, 16'h0);
      else chk("wrt_cmd", cmd, exp_cmd.pop_front());
    end
    if (cnv_cmplt) begin
      cmplt_cnt++;
      if (exp_res.size() == 0) chk("cmplt_unexpected", 16'h1, 16'h0);
      else chk("cmplt_res", 16'(res), 16'(exp_res.pop_front()));
    end
  end

  // SPI master model: done with the next queued rd_data 40 cycles after wrt.
  initial forever begin
    @(negedge clk);
    if (wrt && resp_en) begin
      repeat (40) @(negedge clk);
      resp_done = 1'b1;
      rd_data = (rd_q.size() != 0) ? rd_q.pop_front() : 16'hDEAD;
      @(negedge clk);
      resp_done = 1'b0;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_wrt", 16'(wrt), 16'h0);
    chk("rst_cmplt", 16'(cnv_cmplt), 16'h0);
    chk("rst_err", 16'(err), 16'h0);
    chk("rst_res", 16'(res), 16'h0);
    chk("rst_cmd", cmd, 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of WT1, then a stray done must do nothing.
    exp_cmd.push_back(16'h2800);
    start(3'd5);
    repeat (4) @(negedge clk);
    chk("mid_busy", 16'(busy), 16'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst_wrt", 16'(wrt), 16'h0);
    chk("arst_busy", 16'(busy), 16'h0);
    chk("arst_res", 16'(res), 16'h0);
    chk("arst_err", 16'(err), 16'h0);
    chk("arst_cmd", cmd, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    n0 = wrt_cnt;
    c0 = cmplt_cnt;
    repeat (5) @(negedge clk);
    chk("stray_busy", 16'(busy), 16'h0);
    chk("stray_wrt", 16'(wrt_cnt - n0), 16'h0);
    chk("stray_cmplt", 16'(cmplt_cnt - c0), 16'h0);

`ifdef A2D_AVG4_EN
    // Four passes of 0x100,0x101,0x102,0x105 average to 0x102.
    resp_en = 1'b1;
    rd_q.push_back(16'hABCD); rd_q.push_back(16'hF100);
    rd_q.push_back(16'hABCD); rd_q.push_back(16'h3101);
    rd_q.push_back(16'hABCD); rd_q.push_back(16'h0102);
    rd_q.push_back(16'hABCD); rd_q.push_back(16'h7105);
    repeat (8) exp_cmd.push_back(16'h2000);
    exp_res.push_back(12'h102);
    n0 = wrt_cnt;
    c0 = cmplt_cnt;
    start(3'd4);
    wait_cmplt("avg", 1000);
    repeat (5) @(negedge clk);
    chk("avg_res", 16'(res), 16'h0102);
    chk("avg_wrt_cnt", 16'(wrt_cnt - n0), 16'd8);
    chk("avg_cmplt_cnt", 16'(cmplt_cnt - c0), 16'd1);
    chk("avg_busy", 16'(busy), 16'h0);
`else
    // Single conversion on channel 5.
    resp_en = 1'b1;
    rd_q.push_back(16'hABCD); rd_q.push_back(16'hF123);
    exp_cmd.push_back(16'h2800); exp_cmd.push_back(16'h2800);
    exp_res.push_back(12'h123);
    n0 = wrt_cnt;
    start(3'd5);
    chk("single_busy", 16'(busy), 16'h1);
    wait_cmplt("single", 400);
    chk("single_res", 16'(res), 16'h0123);
    chk("single_wrt_gap", 16'(last_wrt - prev_wrt), 16'd43);
    chk("single_wrt_cnt", 16'(wrt_cnt - n0), 16'd2);
    @(negedge clk);
    chk("single_cmplt_1cyc", 16'(cnv_cmplt), 16'h0);
    chk("single_idle", 16'(busy), 16'h0);

    // Timeout: master silent, err exactly 64 cycles after wrt, res holds.
    resp_en = 1'b0;
    exp_cmd.push_back(16'h1800);
    start(3'd3);
    chk("to_wrt", 16'(wrt), 16'h1);
    repeat (63) @(negedge clk);
    chk("to_err_early", 16'(err), 16'h0);
    chk("to_busy_early", 16'(busy), 16'h1);
    @(negedge clk);
    chk("to_err", 16'(err), 16'h1);
    chk("to_busy", 16'(busy), 16'h0);
    chk("to_res_hold", 16'(res), 16'h0123);
    chk("to_no_cmplt", 16'(cnv_cmplt), 16'h0);
    @(negedge clk);

    // Request while busy is dropped; acceptance clears err.
    resp_en = 1'b1;
    rd_q.push_back(16'hABCD); rd_q.push_back(16'hE456);
    exp_cmd.push_back(16'h1000); exp_cmd.push_back(16'h1000);
    exp_res.push_back(12'h456);
    n0 = wrt_cnt;
    start(3'd2);
    chk("drop_err_clr", 16'(err), 16'h0);
    repeat (5) @(negedge clk);
    start(3'd7);
    chnl = 3'd0;
    wait_cmplt("drop", 400);
    chk("drop_res", 16'(res), 16'h0456);
    repeat (3) @(negedge clk);
    chk("drop_wrt_cnt", 16'(wrt_cnt - n0), 16'd2);

    // Back-to-back: new request in the cnv_cmplt cycle.
    rd_q.push_back(16'hABCD); rd_q.push_back(16'h0789);
    rd_q.push_back(16'hABCD); rd_q.push_back(16'h0ABC);
    exp_cmd.push_back(16'h3000); exp_cmd.push_back(16'h3000);
    exp_cmd.push_back(16'h0800); exp_cmd.push_back(16'h0800);
    exp_res.push_back(12'h789); exp_res.push_back(12'hABC);
    n0 = wrt_cnt;
    start(3'd6);
    wait_cmplt("b2b_a", 400);
    start(3'd1);
    chk("b2b_wrt", 16'(wrt), 16'h1);
    chk("b2b_cmd", cmd, 16'h0800);
    wait_cmplt("b2b_b", 400);
    chk("b2b_res", 16'(res), 16'h0ABC);
    repeat (3) @(negedge clk);
    chk("b2b_wrt_cnt", 16'(wrt_cnt - n0), 16'd4);
`endif

    repeat (3) @(negedge clk);
    chk("exp_cmd_drained", 16'(exp_cmd.size()), 16'h0);
    chk("exp_res_drained", 16'(exp_res.size()), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule

// File: doc/a2d_seq.md
Name: a2d_seq

Overview:
- Conversion sequencer that sits directly upstream of the 16-bit SPI master and consumes what it returns.
- Turns a single-cycle conversion request for one of 8 A2D channels into the two-transaction SPI exchange the A2D requires: transaction 1 selects the channel, transaction 2 returns the result.
- Drives the master's wrt/cmd, watches its done/rd_data, and presents a 12-bit result with a completion pulse and a timeout error to the control logic.

Parameters:
- GAP_CYC, 2: idle clk cycles inserted between done of transaction 1 and wrt of transaction 2 (range 1..15); lets the master return to its idle state.
- TO_CYC, 1024: max clk cycles allowed between issuing wrt and seeing done before aborting (range 64..65535).

Ports:
- clk  input  1  system clock, all state on posedge.
- rst  input  1  asynchronous, active-high reset.
- strt_cnv  input  1  request pulse; accepted only when busy=0.
- chnl  input  3  channel to convert; sampled on the accepting cycle.
- busy  output  1  high from the accepting cycle+1 until return to IDLE.
- cnv_cmplt  output  1  one-cycle pulse, result valid.
- res  output  12  last good conversion result; holds between conversions.
- err  output  1  sticky timeout flag; cleared by the next accepted strt_cnv.
- wrt  output  1  one-cycle transaction start pulse to the SPI master.
- cmd  output  16  command word to the SPI master.
- done  input  1  one-cycle transaction-complete pulse from the SPI master.
- rd_data  input  16  data shifted in by the SPI master; valid in the cycle done=1.

Behaviour:
- Reset values: busy=0, cnv_cmplt=0, res=12'h000, err=0, wrt=0, cmd=16'h0000, state=IDLE, all counters 0.
- Reset mid-operation: wrt drops asynchronously. An in-flight SPI transaction is abandoned, and its later done is ignored in IDLE.
- cmd = {2'b00, chnl_q, 11'h000} for both transactions. chnl_q is registered on acceptance and held until the next acceptance, so cmd is stable while wrt=1.
- FSM states: IDLE, TX1, WT1, GAP, TX2, WT2.
- IDLE: strt_cnv=1 -> latch chnl, clear err, go to TX1. strt_cnv while busy=1 is dropped, with no queueing.
- TX1: wrt=1 for exactly one cycle, clear timeout counter -> WT1. Latency: strt_cnv at cycle 0 -> wrt=1 at cycle 1.
- WT1: done=1 -> GAP with the gap counter cleared. rd_data is discarded.
- GAP: count GAP_CYC cycles -> TX2. done during GAP is ignored.
- TX2: wrt=1 for one cycle -> WT2.
- WT2: done=1 -> res<=rd_data[11:0], cnv_cmplt=1 the following cycle, -> IDLE. rd_data[15:12] is ignored.
- Timeout:
  - In WT1/WT2 the counter increments each cycle.
  - Reaching TO_CYC-1 with done=0 -> err=1, go to IDLE, no cnv_cmplt, res unchanged.
  - done on the same cycle the counter reaches TO_CYC-1: done wins and no timeout is taken.
- busy: busy=1 in all non-IDLE states.
- cnv_cmplt and strt_cnv in the same cycle: the cnv_cmplt cycle is already IDLE, so the new request is accepted.
- Counter widths are sized to their parameter. Counters saturate and do not wrap.

Optional Feature:
- A2D_AVG4_EN defined:
  - One accepted strt_cnv performs 4 back-to-back channel conversions, each a full TX1..WT2 sequence, with GAP_CYC between every done and the next wrt.
  - The four rd_data[11:0] values are summed into a 14-bit accumulator, and res = acc[13:2] (truncating).
  - cnv_cmplt pulses once, after the 4th result.
  - A timeout on any pass aborts all passes, sets err and leaves res unchanged.
  - A 2-bit pass counter resets on acceptance.
- A2D_AVG4_EN undefined: single conversion exactly as in Behaviour; no accumulator or pass counter is synthesized.

Test Plan:
- Reset: assert rst with busy=1 mid-WT1 -> wrt=0, busy=0, res=0, err=0 immediately. Release rst; a stray done causes no activity.
- Single conversion: strt_cnv with chnl=3'd5; model master returns done after 40 cycles each time, with rd_data=16'hF123 on the second -> both wrt pulses carry cmd=16'h2800, the two wrt pulses are separated by 40+1+GAP_CYC cycles, res=12'h123, cnv_cmplt high for 1 cycle.
- Busy drop: strt_cnv with chnl=2 and then again with chnl=7 while busy -> only 2 wrt pulses total, both with cmd=16'h1000.
- Timeout: TO_CYC=64, master never asserts done -> err=1 at 64 cycles after wrt, busy=0, res holds its previous value 12'h123. Next strt_cnv clears err.
- Back-to-back: strt_cnv asserted in the cnv_cmplt cycle with chnl=1 -> new wrt on the next cycle with cmd=16'h0800.
- A2D_AVG4_EN: rd_data values 12'h100, 12'h101, 12'h102, 12'h105 -> 8 wrt pulses, single cnv_cmplt, res=12'h102.
